// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the single-write-port register file: WB has fixed priority,
// and long-latency results drain from a small FIFO. A pending-rd scoreboard stalls issue.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  input  logic        iss_valid,
  input  logic        iss_long,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic [4:0]  iss_rd,
  output logic        stall,
  output logic        rf_wr_en,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wr_data,
  output logic [31:0] pending,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [CW-1:0] starve_cnt;

  logic          empty, full, wb_sel, push, pop, starve;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic [31:0]   set_vec, clr_vec;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c >= CW'(STARVE_LIMIT)) return CW'(STARVE_LIMIT);
    return c + CW'(1);
  endfunction

  // x0 never has a pending result, so index 0 always reads clear.
  function automatic logic pend_hit(input logic [31:0] p, input logic [4:0] r);
    return (r != 5'd0) && p[r];
  endfunction

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_rd   = fifo_rd[rd_ptr[AW-1:0]];
  assign head_data = fifo_data[rd_ptr[AW-1:0]];

  assign wb_sel   = wb_valid && (wb_rd != 5'd0);
  assign pop      = !rst && !wb_sel && !empty;
  assign lu_ready = !full && !rst;
  assign push     = lu_valid && lu_ready && (lu_rd != 5'd0);

  assign rf_wr_en   = !rst && (wb_sel || !empty);
  assign rf_rd      = wb_sel ? wb_rd   : head_rd;
  assign rf_wr_data = wb_sel ? wb_data : head_data;

  assign starve = (starve_cnt == CW'(STARVE_LIMIT));
  assign stall  = !rst && iss_valid &&
                  (pend_hit(pending, iss_rs1) || pend_hit(pending, iss_rs2) ||
                   pend_hit(pending, iss_rd)  || starve);
  assign busy   = !rst && ((pending != 32'd0) || !empty);

  assign set_vec = (iss_valid && iss_long && !stall && (iss_rd != 5'd0)) ? (32'd1 << iss_rd) : 32'd0;
  assign clr_vec = pop ? (32'd1 << head_rd) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending    <= 32'd0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      // Set is ORed in last so a simultaneous set beats the clear.
      pending <= (pending & ~clr_vec) | set_vec;
      if (empty || pop) starve_cnt <= '0;
      else              starve_cnt <= sat_inc(starve_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr[AW-1:0]]   <= lu_rd;
      fifo_data[wr_ptr[AW-1:0]] <= lu_data;
    end
  end

endmodule
